// File: rtl/fifo_access_sched.sv
// Write/read access scheduler for a 16x4 synchronous FIFO: round-robin
// bounded-burst writers plus one reader, never both enables in one cycle.
// Ports: clk, reset (async active-low), req/wdata/gnt (writers),
// rd_req/rd_gnt (reader), fifo_full/fifo_empty in, fifo_wen/fifo_ren/
// fifo_datain out. Define FIFO_ACCESS_SCHED_STATS_EN to add the
// wr_beats/rd_beats/full_stalls saturating counters.
module fifo_access_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  input  logic             rd_req,
  output logic             rd_gnt,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_wen,
  output logic             fifo_ren,
  output logic [DW-1:0]    fifo_datain
`ifdef FIFO_ACCESS_SCHED_STATS_EN
  ,
  output logic [15:0]      wr_beats,
  output logic [15:0]      rd_beats,
  output logic [15:0]      full_stalls
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE,
    WR_BURST
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  state_t          state_q, state_d;
  op_t             last_op_q, last_op_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;

  logic            wr_pend;
  logic            rd_pend;
  logic            found;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] gnt_c;
  logic            rd_c;
  logic [3:0]      beat_nxt;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(NREQ-1)) return '0;
    return p + PW'(1);
  endfunction

  assign wr_pend  = (|req) & ~fifo_full;
  assign rd_pend  = rd_req & ~fifo_empty;
  assign beat_nxt = beat_cnt_q + 4'd1;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    logic [PW-1:0] idx_p;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_p = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_p = PW'(idx);
      if (!found && req[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    last_op_d  = last_op_q;
    gnt_c      = '0;
    rd_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_pend &&
            (last_op_q == OP_WR || !wr_pend)) begin
          rd_c      = 1'b1;
          last_op_d = OP_RD;
        end else if (wr_pend && found) begin
          gnt_c[win] = 1'b1;
          owner_d    = win;
          beat_cnt_d = 4'd1;
          last_op_d  = OP_WR;
          if (MAX_BURST == 1) begin
            rr_ptr_d = ptr_inc(win);
          end else begin
            state_d = WR_BURST;
          end
        end
      end
      WR_BURST: begin
        if (req[owner_q] && !fifo_full) begin
          gnt_c[owner_q] = 1'b1;
          beat_cnt_d     = beat_nxt;
          if (beat_nxt == 4'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(owner_q);
          end
        end else begin
          // Owner dropped or FIFO filled: burn one bubble, re-arbitrate.
          state_d  = IDLE;
          rr_ptr_d = ptr_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      last_op_q  <= OP_RD;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      last_op_q  <= last_op_d;
    end
  end

  // Outputs are forced low whenever reset is held, independent of state.
  assign gnt      = reset ? gnt_c : '0;
  assign rd_gnt   = reset & rd_c;
  assign fifo_wen = |gnt;
  assign fifo_ren = rd_gnt;

  always_comb begin
    fifo_datain = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) fifo_datain = fifo_datain | wdata[i*DW +: DW];
    end
  end

`ifdef FIFO_ACCESS_SCHED_STATS_EN
  logic [15:0] wr_beats_q, wr_beats_d;
  logic [15:0] rd_beats_q, rd_beats_d;
  logic [15:0] full_stalls_q, full_stalls_d;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        en
  );
    if (en && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

  always_comb begin
    wr_beats_d    = sat_inc(wr_beats_q, fifo_wen);
    rd_beats_d    = sat_inc(rd_beats_q, fifo_ren);
    full_stalls_d = sat_inc(full_stalls_q,
                            (|req) & fifo_full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_beats_q    <= '0;
      rd_beats_q    <= '0;
      full_stalls_q <= '0;
    end else begin
      wr_beats_q    <= wr_beats_d;
      rd_beats_q    <= rd_beats_d;
      full_stalls_q <= full_stalls_d;
    end
  end

  assign wr_beats    = wr_beats_q;
  assign rd_beats    = rd_beats_q;
  assign full_stalls = full_stalls_q;
`endif

endmodule
